switch_sequencer: RTL and testbench
===================================

SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the period field and of the inter-pulse counter.
REQ-002 Parameter BURST_W, default 8, width of the burst length and of the pulse counter.
REQ-003 clk  input  1  single core clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request to begin a pulse sequence; level sampled on each rising clk edge.
REQ-006 stop  input  1  request to abort a running sequence; level sampled on each rising clk edge.
REQ-007 period  input  CNT_W  clk cycles between consecutive pulses; latched at start.
REQ-008 burst_len  input  BURST_W  pulses per sequence; 0 = continuous until stop; latched at start.
REQ-009 enable_condition  output  1  one-cycle pulse; drives the downstream receiver's enable_condition input.
REQ-010 busy  output  1  high while the sequencer is in RUN.
REQ-011 done  output  1  one-cycle pulse marking the end of a sequence, whether completed or aborted.
REQ-012 aborted  output  1  valid while done is high; 1 if the sequence ended by stop.
REQ-013 pulse_count  output  BURST_W  pulses issued in the current or last sequence.

Function
REQ-014 FSM states IDLE, RUN, DONE; every output is registered.
REQ-015 IDLE, start=1, stop=0: latch period and burst_len, clear pulse_count, load the inter-pulse counter, go to RUN.
REQ-016 A latched period of 0 is treated as 1.
REQ-017 First pulse: enable_condition high in the cycle starting exactly period edges after the edge that sampled start.
REQ-018 Later pulses: one every period cycles; period=1 keeps enable_condition high continuously.
REQ-019 Each pulse increments pulse_count, which wraps modulo 2^BURST_W in continuous mode.
REQ-020 burst_len!=0: the edge that issues pulse number burst_len moves the FSM to DONE; no further pulses.
REQ-021 RUN with stop=1: go to DONE with aborted=1; a pulse due on that same edge is suppressed.
REQ-022 DONE lasts exactly one cycle with done=1, then returns to IDLE; aborted keeps its value until the next start.
REQ-023 start while in RUN or DONE is ignored; period and burst_len changes during RUN are ignored.
REQ-024 IDLE with start=1 and stop=1: stop wins and the FSM stays in IDLE.
REQ-025 stop in IDLE or DONE has no effect.

Reset
REQ-026 reset=0 forces IDLE immediately, regardless of clk.
REQ-027 While reset=0: enable_condition=0, busy=0, done=0, aborted=0, pulse_count=0, all counters 0.
REQ-028 Reset during RUN discards the sequence without generating a done pulse.
REQ-029 First valid start is sampled on the first rising edge after reset returns high.

Configuration
REQ-030 Macro SWITCH_SEQ_SYNC_EN defined: start and stop each pass through a two-flop synchronizer before the FSM, and all start/stop-relative timing gains 2 cycles.
REQ-031 SWITCH_SEQ_SYNC_EN undefined: start and stop feed the FSM directly with the timing in REQ-017 and REQ-021.

Structure
REQ-032 A shared package switch_seq_pkg holds the FSM state enum, and the default values of CNT_W and BURST_W as constants.
REQ-033 Sub-module sync2 implements the two-flop synchronizer, is reset by the same reset, and is instantiated only under SWITCH_SEQ_SYNC_EN.

Verification
REQ-034 period=4, burst_len=3, start pulsed in IDLE -> pulses at start+4, +8, +12; done at +13 with aborted=0; pulse_count=3.
REQ-035 period=0, burst_len=2 -> pulses on the two consecutive cycles after start; then done=1 for one cycle.
REQ-036 period=5, burst_len=0, stop asserted on the edge of the 3rd pulse -> 2 pulses only; done=1, aborted=1, pulse_count=2.
REQ-037 start=1 and stop=1 together in IDLE -> busy stays 0; no pulse within 100 cycles.
REQ-038 reset driven low mid-RUN, off-edge -> all outputs 0 immediately; no done pulse; a restart after reset rises follows REQ-034 timing.
REQ-039 SWITCH_SEQ_SYNC_EN defined, rerun REQ-034 -> every pulse and done arrive 2 cycles later.

Source files
------------

// File: rtl/switch_seq_pkg.sv
// rtl/switch_seq_pkg.sv - shared FSM state type and default widths for switch_sequencer
package switch_seq_pkg;

   localparam int CNT_W_DEFAULT   = 16;
   localparam int BURST_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop level synchronizer for start/stop (used with SWITCH_SEQ_SYNC_EN)
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/switch_sequencer.sv
// rtl/switch_sequencer.sv - periodic enable_condition pulse sequencer; SWITCH_SEQ_SYNC_EN adds start/stop synchronizers
module switch_sequencer
   import switch_seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int BURST_W = BURST_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [CNT_W-1:0]   period,
   input  logic [BURST_W-1:0] burst_len,
   output logic               enable_condition,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [BURST_W-1:0] pulse_count
);

   logic start_i;
   logic stop_i;

`ifdef SWITCH_SEQ_SYNC_EN
   sync2 u_sync_start (.clk(clk), .reset(reset), .d(start), .q(start_i));
   sync2 u_sync_stop  (.clk(clk), .reset(reset), .d(stop),  .q(stop_i));
`else
   assign start_i = start;
   assign stop_i  = stop;
`endif

   seq_state_t         state, state_n;
   logic [CNT_W-1:0]   per_q, per_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [BURST_W-1:0] blen_q, blen_n;
   logic [BURST_W-1:0] pc_n;
   logic               en_n, busy_n, done_n, ab_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         per_q            <= '0;
         cnt_q            <= '0;
         blen_q           <= '0;
         pulse_count      <= '0;
         enable_condition <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         aborted          <= 1'b0;
      end else begin
         state            <= state_n;
         per_q            <= per_n;
         cnt_q            <= cnt_n;
         blen_q           <= blen_n;
         pulse_count      <= pc_n;
         enable_condition <= en_n;
         busy             <= busy_n;
         done             <= done_n;
         aborted          <= ab_n;
      end
   end

   // cnt_q counts down to 1; the edge that sees 1 issues the pulse and reloads
   // the latched period, so the first pulse lands exactly period edges after start.
   always_comb begin
      state_n = state;
      per_n   = per_q;
      cnt_n   = cnt_q;
      blen_n  = blen_q;
      pc_n    = pulse_count;
      en_n    = 1'b0;
      done_n  = 1'b0;
      ab_n    = aborted;
      case (state)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               per_n   = (period == '0) ? CNT_W'(1) : period;
               cnt_n   = per_n;
               blen_n  = burst_len;
               pc_n    = '0;
               ab_n    = 1'b0;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               ab_n    = 1'b1;
               state_n = ST_DONE;
            end else if (cnt_q == CNT_W'(1)) begin
               en_n  = 1'b1;
               pc_n  = pulse_count + BURST_W'(1);
               cnt_n = per_q;
               if ((blen_q != '0) && (pc_n == blen_q))
                  state_n = ST_DONE;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      busy_n = (state_n == ST_RUN);
   end

endmodule

// File: tb/tb_switch_sequencer.sv
// tb/tb_switch_sequencer.sv - directed self-checking bench for switch_sequencer (honours SWITCH_SEQ_SYNC_EN)
module tb_switch_sequencer;

`ifdef SWITCH_SEQ_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] period = '0;
   logic [7:0]  burst_len = '0;
   logic        enable_condition;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [7:0]  pulse_count;

   int n_checks = 0;
   int n_err    = 0;

   switch_sequencer #(.CNT_W(16), .BURST_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .stop(stop),
      .period(period),
      .burst_len(burst_len),
      .enable_condition(enable_condition),
      .busy(busy),
      .done(done),
      .aborted(aborted),
      .pulse_count(pulse_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected pulses at L + pe*i (i=1..blen), done one cycle after the last pulse.
   task automatic run_burst(input int per, input int blen, input bit poke);
      int pe;
      pe = (per == 0) ? 1 : per;
      period    = 16'(per);
      burst_len = 8'(blen);
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= pe * blen + L + 2; k++) begin
         tick();
         chk("pulse", enable_condition, (k > L) && (k <= L + pe * blen) && ((k - L) % pe == 0));
         chk("done", done, k == L + pe * blen + 1);
         chk("busy", busy, (k >= L) && (k < L + pe * blen));
         if (k == L + pe * blen + 1) chk("aborted_clean", aborted, 0);
         if (poke && k == 2) begin
            start     = 1'b1;
            period    = 16'd1;
            burst_len = 8'd1;
         end
         if (poke && k == 3) start = 1'b0;
      end
      chk("pulse_count", pulse_count, blen);
   endtask

   initial begin
      #2;
      chk("rst_en", enable_condition, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_pc", pulse_count, 0);
      #10;
      reset = 1'b1;
      tick();

      run_burst(4, 3, 1'b0);
      run_burst(0, 2, 1'b0);

      // continuous mode aborted by stop on the edge of the 3rd pulse
      period    = 16'd5;
      burst_len = 8'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 20 + L; k++) begin
         tick();
         chk("stop_pulse", enable_condition, (k == 5 + L) || (k == 10 + L));
         chk("stop_done", done, k == 16 + L);
         if (k == 16 + L) chk("stop_aborted", aborted, 1);
         if (k == 14) stop = 1'b1;
         if (k == 15) stop = 1'b0;
      end
      chk("stop_aborted_hold", aborted, 1);
      chk("stop_pc", pulse_count, 2);

      // start and stop together in IDLE: stop wins
      period    = 16'd1;
      burst_len = 8'd0;
      start     = 1'b1;
      stop      = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         chk("both_busy", busy, 0);
         chk("both_pulse", enable_condition, 0);
      end

      // asynchronous reset mid-RUN
      period    = 16'd4;
      burst_len = 8'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 6 + L; k++) tick();
      chk("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_en", enable_condition, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_aborted", aborted, 0);
      chk("arst_pc", pulse_count, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("arst_no_done", done, 0);
         chk("arst_no_pulse", enable_condition, 0);
      end
      #2;
      reset = 1'b1;
      run_burst(4, 3, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
